// File: rtl/vga_capture.sv
// vga_capture: grabs one subsampled greyscale frame from a 6-bit VGA stream into a frame buffer
module vga_capture #(
  parameter int WIDTH   = 128,
  parameter int HEIGHT  = 96,
  parameter int H_TOTAL = 800,
  parameter int H_BP    = 48,
  parameter int V_BP    = 29,
  parameter int IMG_X0  = 64,
  parameter int IMG_Y0  = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  rgb,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        arm,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        sync_err
);
  // hcnt/vcnt value of the first sample and the span covered by the 4x subsampled window
  localparam logic [9:0]  HS    = 10'(H_BP + IMG_X0);
  localparam logic [9:0]  VS    = 10'(V_BP + IMG_Y0);
  localparam logic [9:0]  HSPAN = 10'(4 * WIDTH);
  localparam logic [9:0]  VSPAN = 10'(4 * HEIGHT);
  localparam logic [9:0]  HLAST = 10'(H_TOTAL - 1);
  localparam logic [13:0] LAST  = 14'(WIDTH * HEIGHT - 1);
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} state_t;
  state_t      state;
  logic        first_line;
  logic [5:0]  rgb_q, rgb_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [9:0]  hcnt, vcnt, hoff, voff;
  logic        hs_rise, vs_rise, hit;
  logic [7:0]  sum, grey;
  logic [13:0] addr;
  // rgb_d lines up with hcnt: when hcnt == k, rgb_d holds the pixel k clocks after the hsync rise
  assign hs_rise = hs_q & ~hs_d;
  assign vs_rise = vs_q & ~vs_d;
  assign hoff    = hcnt - HS;
  assign voff    = vcnt - VS;
  assign hit     = hcnt >= HS && hoff < HSPAN && hoff[1:0] == 2'b00 &&
                   vcnt >= VS && voff < VSPAN && voff[1:0] == 2'b00;
  assign addr    = 14'(voff[9:2]) * 14'(WIDTH) + 14'(hoff[9:2]);
  assign sum     = 8'(rgb_d[5:4]) + 8'(rgb_d[3:2]) + 8'(rgb_d[1:0]);
  assign grey    = sum * 8'd28;
  // input pipeline and raster counters; syncs idle high so reset release produces no edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= '0;
      rgb_d <= '0;
      hs_q  <= 1'b1;
      hs_d  <= 1'b1;
      vs_q  <= 1'b1;
      vs_d  <= 1'b1;
      hcnt  <= '0;
      vcnt  <= '0;
    end else begin
      rgb_q <= rgb;
      rgb_d <= rgb_q;
      hs_q  <= hsync;
      hs_d  <= hs_q;
      vs_q  <= vsync;
      vs_d  <= vs_q;
      hcnt  <= hs_rise ? '0 : (hcnt == 10'h3ff ? hcnt : hcnt + 10'd1);
      vcnt  <= vs_rise ? '0 : (hs_rise ? vcnt + 10'd1 : vcnt);
    end
  end
  // capture control with registered write port and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      first_line <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: if (arm) begin
          state    <= WAIT_FRAME;
          sync_err <= 1'b0;
          busy     <= 1'b1;
        end
        WAIT_FRAME: if (vs_rise) begin
          state      <= CAPTURE;
          first_line <= 1'b1;
        end
        CAPTURE: if (vs_rise || (hs_rise && !first_line && hcnt != HLAST)) begin
          sync_err <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end else begin
          if (hs_rise) first_line <= 1'b0;
          if (hit) begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= grey;
            if (addr == LAST) state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 128: captured image width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 96: captured image height in pixels.
REQ-003 SHALL have parameter H_TOTAL, default 800: expected clocks per line.
REQ-004 SHALL have parameter H_BP, default 48: clocks from hsync rising edge to active column 0.
REQ-005 SHALL have parameter V_BP, default 29: line count from vsync rising edge to active line 0.
REQ-006 SHALL have parameters IMG_X0 = 64 and IMG_Y0 = 48: image window origin in active pixels.
REQ-007 SHALL have port clk, input, 1 bit: single clock for all logic, rising edge, one clock per pixel.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port rgb, input, 6 bits: pixel colour {R[1:0],G[1:0],B[1:0]}.
REQ-010 SHALL have ports hsync and vsync, input, 1 bit each: active-low sync pulses.
REQ-011 SHALL have port arm, input, 1 bit: one-cycle request to capture the next full frame.
REQ-012 SHALL have port wr_en, output, 1 bit: frame-buffer write strobe.
REQ-013 SHALL have port wr_addr, output, 14 bits: frame-buffer address = row*WIDTH + col.
REQ-014 SHALL have port wr_data, output, 8 bits: grey value.
REQ-015 SHALL have ports busy, done, and sync_err, output, 1 bit each.

Function
REQ-016 SHALL register rgb, hsync and vsync once (q stage); all decoding uses the q stage and its one-cycle-delayed copy.
REQ-017 SHALL clear hcnt (10 bits) on a q-stage hsync rising edge; otherwise hcnt SHALL increment, saturating at 1023.
REQ-018 SHALL clear vcnt (10 bits) on a q-stage vsync rising edge; otherwise vcnt SHALL increment on each hsync rising edge. If both edges occur in the same cycle, the vsync clear wins.
REQ-019 SHALL define the sample point as hcnt == H_BP+IMG_X0+4*c and vcnt == V_BP+IMG_Y0+4*r, with c in 0..WIDTH-1 and r in 0..HEIGHT-1.
REQ-020 SHALL compute grey = (R+G+B)*28, which is 0..252 and always fits in 8 bits.
REQ-021 SHALL drive wr_en high for exactly one cycle, one cycle after each sample point in state CAPTURE, with wr_addr = r*WIDTH + c and wr_data = grey of that sample.
REQ-022 SHALL implement an FSM with states IDLE, WAIT_FRAME, CAPTURE and DONE.
REQ-023 IDLE: on arm go to WAIT_FRAME, clear sync_err, and set busy = 1.
REQ-024 WAIT_FRAME: on a vsync rising edge go to CAPTURE; partial frames are never captured.
REQ-025 CAPTURE: after the write of address WIDTH*HEIGHT-1, go to DONE.
REQ-026 DONE: pulse done for one cycle, clear busy, then go to IDLE.
REQ-027 SHALL ignore arm in WAIT_FRAME, CAPTURE and DONE.
REQ-028 In CAPTURE, an hsync rising edge whose preceding hcnt != H_TOTAL-1 SHALL set sync_err and return to IDLE with busy = 0 and no done. The first line after the vsync rise is exempt from this check.
REQ-029 In CAPTURE, a vsync rising edge before the last write SHALL set sync_err and return to IDLE.
REQ-030 sync_err SHALL be sticky until the next accepted arm or reset.
REQ-031 Pixels outside the window, or outside CAPTURE, SHALL never assert wr_en.

Reset
REQ-032 While rst = 0, the block SHALL be in IDLE with all counters cleared, q stages set to hsync = 1, vsync = 1, rgb = 0, and wr_en, wr_addr, wr_data, busy, done and sync_err all 0.
REQ-033 Reset mid-capture SHALL abort immediately with no further writes; after release, a new arm is required.

Verification
REQ-034 Scenario 1: nominal 800x521 timing, arm, constant rgb = 6'b111111 -> exactly 12288 writes, addresses 0..12287 ascending, wr_data = 252, then one done pulse.
REQ-035 Scenario 2: arm mid-frame -> no writes until after the next vsync rise; the first write has wr_addr = 0.
REQ-036 Scenario 3: source pattern rgb = 6'b010101 only at active pixel (x=68, y=52), 0 elsewhere -> wr_addr 129 carries wr_data 84; all other addresses carry 0.
REQ-037 Scenario 4: one line shortened to 799 clocks during capture -> sync_err = 1, busy = 0, no done, no writes afterwards.
REQ-038 Scenario 5: rst low after 5000 writes -> outputs 0 immediately; a re-arm yields a full 12288-write frame.
REQ-039 Scenario 6: arm pulsed again during CAPTURE -> ignored; exactly one done pulse.
